// File: rtl/fft_bfly_r2_stage_if.sv
// Handshake and data bundle for the radix-2 butterfly stage: input pair side and output pair side.
interface fft_bfly_r2_stage_if #(
    parameter int DW = 10
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_a;
    logic signed [DW-1:0] in_b;
    logic [1:0]           tw_ctl;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_p;
    logic signed [DW-1:0] out_m;
    logic                 out_last;

    modport master (
        output in_valid, in_a, in_b, tw_ctl, out_ready,
        input  in_ready, out_valid, out_p, out_m, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, tw_ctl, out_ready,
        output in_ready, out_valid, out_p, out_m, out_last
    );
endinterface

// File: rtl/fft_bfly_r2_stage.sv
// Radix-2 butterfly with trivial twiddles (0, +1, -1): two-stage pipeline, frame tracking, sticky flags.
// Define FFT_BFLY_SAT_EN to saturate out-of-range results instead of wrapping them.
module fft_bfly_r2_stage #(
    parameter int DW        = 10,
    parameter int FRAME_LEN = 8,
    parameter int SCALE     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    fft_bfly_r2_stage_if.slave    bus,
    output logic                  ovf,
    output logic                  err_tw
);
    localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    logic                 en;
    logic                 in_xfer;
    logic [CW-1:0]        cnt_q, cnt_d, idx;
    logic                 v1_q, v2_q;
    logic signed [DW-1:0] a1_q;
    logic signed [DW:0]   wb1_q, wb_d, b_ext;
    logic                 last1_q, last2_q;
    logic signed [DW+1:0] p_full, m_full, p_sc, m_sc;
    logic                 p_oor, m_oor;
    logic signed [DW-1:0] p_res, m_res, p2_q, m2_q;
    logic                 ovf_q, ovf_d, err_q, err_d;

    // A stall freezes both stages together, so stage 1 only advances when stage 2 can.
    assign en           = !v2_q || bus.out_ready;
    assign in_xfer      = bus.in_valid && en;
    assign bus.in_ready = en;
    assign bus.out_valid = v2_q;
    assign bus.out_p    = p2_q;
    assign bus.out_m    = m2_q;
    assign bus.out_last = last2_q;
    assign ovf          = ovf_q;
    assign err_tw       = err_q;

    // clr coinciding with a transfer makes that pair position 0.
    assign idx = clr ? '0 : cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (in_xfer) begin
            cnt_d = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else if (clr) begin
            cnt_d = '0;
        end
    end

    // One extra bit so negating the most negative sample is exact.
    assign b_ext = {bus.in_b[DW-1], bus.in_b};

    always_comb begin
        wb_d = '0;
        case (bus.tw_ctl)
            2'b01:   wb_d = b_ext;
            2'b11:   wb_d = -b_ext;
            default: wb_d = '0;
        endcase
    end

    assign p_full = {{2{a1_q[DW-1]}}, a1_q} + {wb1_q[DW], wb1_q};
    assign m_full = {{2{a1_q[DW-1]}}, a1_q} - {wb1_q[DW], wb1_q};
    assign p_sc   = (SCALE != 0) ? (p_full >>> 1) : p_full;
    assign m_sc   = (SCALE != 0) ? (m_full >>> 1) : m_full;

    // In range exactly when the top three bits agree.
    assign p_oor = (|p_sc[DW+1:DW-1]) && !(&p_sc[DW+1:DW-1]);
    assign m_oor = (|m_sc[DW+1:DW-1]) && !(&m_sc[DW+1:DW-1]);

`ifdef FFT_BFLY_SAT_EN
    assign p_res = !p_oor ? p_sc[DW-1:0] :
                   (p_sc[DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
    assign m_res = !m_oor ? m_sc[DW-1:0] :
                   (m_sc[DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
`else
    assign p_res = p_sc[DW-1:0];
    assign m_res = m_sc[DW-1:0];
`endif

    // Set wins over a simultaneous clr.
    assign ovf_d = (ovf_q && !clr) || (en && v1_q && (p_oor || m_oor));
    assign err_d = (err_q && !clr) || (in_xfer && (bus.tw_ctl == 2'b10));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            a1_q    <= '0;
            wb1_q   <= '0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            p2_q    <= '0;
            m2_q    <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            if (en) begin
                v1_q    <= in_xfer;
                a1_q    <= bus.in_a;
                wb1_q   <= wb_d;
                last1_q <= in_xfer && (idx == LAST_IDX);
                v2_q    <= v1_q;
                last2_q <= v1_q && last1_q;
                if (v1_q) begin
                    p2_q <= p_res;
                    m2_q <= m_res;
                end
            end
        end
    end
endmodule

// File: doc/fft_bfly_r2_stage.md
Name: fft_bfly_r2_stage

Overview:
- Radix-2 butterfly stage that sits directly downstream of the trivial-twiddle conditional-negate logic in the FFT pipeline.
- Accepts a sample pair (a, b) plus a twiddle control code, forms w*b with w in {0, +1, -1}, and emits a+w*b and a-w*b.
- Two-stage pipeline with valid/ready handshake, frame-position tracking and a sticky overflow flag.
- Feeds the next stage's reorder buffer.

Parameters:
- DW, 10, sample width in bits, signed two's complement.
- FRAME_LEN, 8, butterflies per frame; out_last marks the final one. Must be >= 2.
- SCALE, 0, 1 = outputs arithmetically shifted right by 1 (divide by 2, floor); 0 = unscaled.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  stage can accept the input pair.
- in_a  in  DW  butterfly top input, signed.
- in_b  in  DW  butterfly bottom input, signed.
- tw_ctl  in  2  twiddle code: 00 -> w=0; 01 -> w=+1; 11 -> w=-1; 10 -> w=0 and sets err_tw.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts the output pair.
- out_p  out  DW  a + w*b.
- out_m  out  DW  a - w*b.
- out_last  out  1  qualifies the FRAME_LEN-th output pair of a frame.
- ovf  out  1  sticky: an arithmetic result exceeded the DW range.
- err_tw  out  1  sticky: reserved tw_ctl code 10 was accepted.
- clr  in  1  synchronous clear of ovf, err_tw and the frame counter.

Behaviour:
- Reset: all valids 0; out_p, out_m, out_last, ovf and err_tw are 0; frame counter is 0. Reset may assert mid-operation: in-flight data is discarded and no partial output is seen.
- Pipeline enable: en = !v2 | out_ready, where v2 is the stage-2 valid. in_ready = en, purely combinational from v2 and out_ready.
- Input transfer: in_valid & in_ready.
- Output transfer: out_valid & out_ready. out_valid = v2.
- Holding: while out_valid=1 and out_ready=0, out_p, out_m and out_last hold stable.
- Stage 1 (on en): registers a; registers wb = 0, b or -b; registers last-flag; v1 <= input transfer.
  - wb is computed DW+1 bits wide, so -(-2^(DW-1)) is exact.
- Stage 2 (on en): computes p = a + wb and m = a - wb in DW+2 bits, then applies SCALE, then range handling.
  - v2 <= v1.
- Latency: 2 cycles from accepted input to out_valid when out_ready is held high. Throughput is 1 pair/cycle.
  - There are no bubbles; a stall freezes both stages together.
- Frame counter: increments on each input transfer. Wraps from FRAME_LEN-1 to 0.
  - The pair accepted at count FRAME_LEN-1 carries last=1 through the pipeline.
- clr (sync, priority below rst):
  - Zeroes the frame counter and clears ovf and err_tw.
  - clr together with an input transfer in the same cycle: that pair is treated as count 0 and the counter becomes 1.
  - clr together with a new overflow in the same cycle: ovf ends at 1 (set wins).
- ovf: set in stage 2 on an enabled cycle with v1=1 whenever p or m (after scaling) lies outside [-2^(DW-1), 2^(DW-1)-1].
- err_tw: set on an input transfer carrying tw_ctl=10.
- Range handling: out_p and out_m take the low DW bits of the result (wrap) unless the optional feature below is compiled in.

Optional Feature:
- Macro: FFT_BFLY_SAT_EN.
- Defined: out-of-range p or m saturate to +2^(DW-1)-1 or -2^(DW-1). ovf is still set.
- Not defined: two's-complement wrap to DW bits; ovf is set identically.

Test Plan:
- Basic: DW=10, SCALE=0, out_ready=1, a=100, b=30, tw=01 -> 2 cycles later out_p=130, out_m=70, ovf=0. Same pair with tw=11 -> out_p=70, out_m=130.
- Zero twiddle and reserved code: a=-5, b=200, tw=00 -> out_p=out_m=-5. Next pair with tw=10 -> out_p=out_m=a and err_tw=1 from the following cycle; clr pulse -> err_tw=0.
- Overflow: a=511, b=1, tw=01 -> ovf=1; out_p=-512 (wrap) or 511 (FFT_BFLY_SAT_EN); out_m=510. a=-512, b=-512, tw=11 -> out_p=0, out_m=-1024, which is out of range and sets ovf.
- Scaling: SCALE=1, a=-3, b=0, tw=01 -> out_p=out_m=-2 (floor). a=511, b=511, tw=01 -> out_p=511, ovf=0.
- Backpressure: stream 8 pairs with out_ready toggling 1,0,0,1 -> in_ready=0 whenever v2=1 & out_ready=0; output held stable while stalled; all 8 results in order, none lost or duplicated; out_last high only on the 8th pair; the 9th pair starts a new frame.
- Reset mid-stream: rst asserted with v1=v2=1 -> out_valid=0 and outputs 0 immediately (async). After release, first accepted pair is count 0 and out_last follows on the FRAME_LEN-th pair.
